alu_seq_param: RTL and testbench

Parametrised, registered successor to the 16-bit ripple ALU.
- Generalised to WIDTH bits.
- Adds SLT, shift-left, shift-right and a multi-cycle shift-add multiply.
- Adds Negative and Overflow flags.
- Wraps the datapath in a valid/ready handshake so the CPU control FSM can stall on multi-cycle ops.
- Sits between the register-file read stage and writeback in the 16-bit CPU.

---
 rtl/alu_pkg.sv | 12 +
 rtl/alu_comb_datapath.sv | 42 ++++
 rtl/alu_seq_param.sv | 86 ++++++++
 tb/tb_alu_seq_param.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state encodings shared by the sequential ALU
package alu_pkg;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
endpackage

// File: rtl/alu_comb_datapath.sv
// alu_comb_datapath: combinational result and flags for every single-cycle opcode
module alu_comb_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry_out,
    output logic             overflow
);
    logic             sub;
    logic             arith;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   sh;
    logic             lt;
    assign sub   = op == OP_SUB;
    assign arith = op == OP_ADD || op == OP_SUB;
    assign bb    = sub ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
    assign sh    = b[SHW-1:0];
    assign lt    = $signed(a) < $signed(b);
    // Opcode select; MUL is handled by the sequential engine so it yields zero here
    always_comb begin
        result = op == OP_AND ? a & b :
                 op == OP_OR  ? a | b :
                 arith        ? sum[WIDTH-1:0] :
                 op == OP_SLT ? {{(WIDTH-1){1'b0}}, lt} :
                 op == OP_SLL ? a << sh :
                 op == OP_SRL ? a >> sh : '0;
    end
    assign zero      = ~|result;
    assign negative  = result[WIDTH-1];
    assign carry_out = arith & sum[WIDTH];
    assign overflow  = arith & (a[WIDTH-1] == bb[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/alu_seq_param.sv
// alu_seq_param: registered ALU with valid/ready handshake and shift-add multiplier
module alu_seq_param
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry_out,
    output logic             overflow
);
    localparam logic [SHW:0] LAST = WIDTH[SHW:0];
    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [SHW:0]       counter;
    logic [WIDTH-1:0]   d_result;
    logic               d_zero, d_negative, d_carry, d_overflow;
    alu_comb_datapath #(.WIDTH(WIDTH), .SHW(SHW)) u_dp (
        .op(op), .a(a), .b(b), .result(d_result), .zero(d_zero),
        .negative(d_negative), .carry_out(d_carry), .overflow(d_overflow)
    );
    assign in_ready  = state == ST_IDLE;
    assign out_valid = state == ST_DONE;
    assign acc_next  = mplier[counter[SHW-1:0]] ? acc + ({{WIDTH{1'b0}}, mcand} << counter) : acc;
    // Handshake FSM, multiply iteration and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            result    <= '0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            counter   <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    if (op == OP_MUL) begin
                        mcand   <= a;
                        mplier  <= b;
                        acc     <= '0;
                        counter <= '0;
                        state   <= ST_BUSY;
                    end else begin
                        result    <= d_result;
                        zero      <= d_zero;
                        negative  <= d_negative;
                        carry_out <= d_carry;
                        overflow  <= d_overflow;
                        state     <= ST_DONE;
                    end
                end
                ST_BUSY: if (counter == LAST) begin
                    result    <= acc[WIDTH-1:0];
                    zero      <= ~|acc[WIDTH-1:0];
                    negative  <= acc[WIDTH-1];
                    carry_out <= |acc[2*WIDTH-1:WIDTH];
                    overflow  <= 1'b0;
                    state     <= ST_DONE;
                end else begin
                    acc     <= acc_next;
                    counter <= counter + 1'b1;
                end
                ST_DONE: if (out_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_param.sv
// tb_alu_seq_param: scoreboard bench for the sequential ALU at WIDTH=16
module tb_alu_seq_param;
    import alu_pkg::*;
    typedef struct packed {
        logic [15:0] r;
        logic        z, n, c, v;
    } exp_t;
    logic        clk = 0, reset = 0, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid, zero, negative, carry_out, overflow;
    logic [2:0]  op = 0;
    logic [15:0] a = 0, b = 0, result;
    exp_t        q[$];
    int          n = 0, fails = 0;
    alu_seq_param #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .negative(negative), .carry_out(carry_out), .overflow(overflow)
    );
    always #5 clk = ~clk;
    function automatic exp_t model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        longint ux = x, uy = y, sx = $signed(x), sy = $signed(y), r = 0, s;
        exp_t e;
        e.c = 0;
        e.v = 0;
        case (o)
            OP_AND: r = ux & uy;
            OP_OR:  r = ux | uy;
            OP_ADD: begin r = ux + uy; s = sx + sy; e.c = r[16]; e.v = s > 32767 || s < -32768; end
            OP_SUB: begin r = ux + ((~uy) & 64'hFFFF) + 1; s = sx - sy; e.c = r[16]; e.v = s > 32767 || s < -32768; end
            OP_SLT: r = (sx < sy) ? 1 : 0;
            OP_MUL: begin r = ux * uy; e.c = (r >> 16) != 0; end
            OP_SLL: r = ux << (uy % 16);
            default: r = ux >> (uy % 16);
        endcase
        e.r = r[15:0];
        e.z = e.r == 0;
        e.n = e.r[15];
        return e;
    endfunction
    function automatic exp_t obs();
        return {result, zero, negative, carry_out, overflow};
    endfunction
    task automatic send(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        int k = 0;
        while (!in_ready && k < 100) begin @(posedge clk); #1; k++; end
        if (!in_ready) begin n++; fails++; $display("FAIL send_wait: in_ready=%b required 1", in_ready); end
        op = o; a = x; b = y; in_valid = 1;
        q.push_back(model(o, x, y));
        @(posedge clk); #1;
        in_valid = 0; a = 16'hDEAD; b = 16'hBEEF;
    endtask
    // lat = edges after the accept edge until out_valid is seen
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        if (!out_valid) begin n++; fails++; $display("FAIL out_timeout: out_valid=%b required 1", out_valid); end
    endtask
    task automatic release_out();
        out_ready = 1; @(posedge clk); #1; out_ready = 0;
    endtask
    task automatic test_reset();
        reset = 1; repeat (2) @(posedge clk); #1;
        n++; if ({obs(), out_valid, in_ready} !== {20'h0, 1'b0, 1'b1}) begin fails++;
            $display("FAIL reset_state: got %h ov=%b ir=%b required 00000 0 1", obs(), out_valid, in_ready); end
        reset = 0; @(posedge clk); #1;
        n++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++;
            $display("FAIL post_reset: ov=%b ir=%b required 0 1", out_valid, in_ready); end
    endtask
    task automatic test_add();
        exp_t e; int lat;
        send(OP_ADD, 16'hFFFF, 16'h0001); wait_out(lat); e = q.pop_front();
        n++; if (lat !== 0) begin fails++; $display("FAIL add_latency: got %0d required 0", lat); end
        n++; if (obs() !== e || e !== {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}) begin fails++;
            $display("FAIL add_ffff: got %h required %h", obs(), e); end
        release_out();
        n++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++;
            $display("FAIL add_release: ir=%b ov=%b required 1 0", in_ready, out_valid); end
    endtask
    task automatic test_sub();
        exp_t e; int lat;
        send(OP_SUB, 16'h7FFF, 16'hFFFF); wait_out(lat); e = q.pop_front();
        n++; if (obs() !== e || e !== {16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}) begin fails++;
            $display("FAIL sub_ovf: got %h required %h", obs(), e); end
        release_out();
        send(OP_SUB, 16'd5, 16'd5); wait_out(lat); e = q.pop_front();
        n++; if (obs() !== e || e !== {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}) begin fails++;
            $display("FAIL sub_equal: got %h required %h", obs(), e); end
        release_out();
    endtask
    task automatic test_mul();
        exp_t e; int lat = 0; bit busy_ok = 1;
        send(OP_MUL, 16'd300, 16'd300);
        in_valid = 1; op = OP_ADD; a = 16'h0001; b = 16'h0001;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_ok = 0;
            a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1; lat++;
        end
        in_valid = 0;
        e = q.pop_front();
        n++; if (!busy_ok) begin fails++; $display("FAIL mul_busy_ready: in_ready seen 1 while busy"); end
        n++; if (lat !== 17) begin fails++; $display("FAIL mul_latency: got %0d required 17", lat); end
        n++; if (obs() !== e || e !== {16'h5F90, 1'b0, 1'b0, 1'b1, 1'b0}) begin fails++;
            $display("FAIL mul_300: got %h required %h", obs(), e); end
        release_out();
    endtask
    task automatic test_slt_shift();
        logic [2:0]  ops[6] = '{OP_SLT, OP_SRL, OP_SLL, OP_SLL, OP_SRL, OP_SLT};
        logic [15:0] as[6]  = '{16'hFFFE, 16'h8000, 16'hA5C3, 16'h0003, 16'h8001, 16'h0001};
        logic [15:0] bs[6]  = '{16'h0001, 16'h001F, 16'h0000, 16'hFFF4, 16'h0000, 16'hFFFE};
        logic [15:0] rs[6]  = '{16'h0001, 16'h0001, 16'hA5C3, 16'h0030, 16'h8001, 16'h0000};
        exp_t e; int lat;
        for (int i = 0; i < 6; i++) begin
            send(ops[i], as[i], bs[i]); wait_out(lat); e = q.pop_front();
            n++; if (obs() !== e || result !== rs[i] || lat !== 0) begin fails++;
                $display("FAIL slt_shift_%0d: got %h lat %0d required %h (result %h) lat 0", i, obs(), lat, e, rs[i]); end
            release_out();
        end
    endtask
    task automatic test_backpressure();
        exp_t e; int lat;
        send(OP_ADD, 16'h1234, 16'h4321); wait_out(lat); e = q.pop_front();
        for (int i = 0; i < 5; i++) begin
            n++; if (obs() !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin fails++;
                $display("FAIL hold_%0d: got %h ov=%b ir=%b required %h 1 0", i, obs(), out_valid, in_ready, e); end
            @(posedge clk); #1;
        end
        release_out();
        n++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++;
            $display("FAIL hold_release: ir=%b ov=%b required 1 0", in_ready, out_valid); end
    endtask
    task automatic test_reset_mid_mul();
        exp_t e; int lat;
        send(OP_MUL, 16'd300, 16'd300);
        repeat (7) @(posedge clk); #1;
        reset = 1; @(posedge clk); #1; reset = 0;
        q.delete();
        n++; if (out_valid !== 1'b0 || result !== 16'h0 || in_ready !== 1'b1) begin fails++;
            $display("FAIL mid_mul_reset: ov=%b result=%h ir=%b required 0 0000 1", out_valid, result, in_ready); end
        send(OP_ADD, 16'd2, 16'd3); wait_out(lat); e = q.pop_front();
        n++; if (obs() !== e || result !== 16'd5) begin fails++;
            $display("FAIL add_after_reset: got %h required %h", obs(), e); end
        release_out();
    endtask
    task automatic test_back_to_back();
        exp_t e; int lat;
        for (int i = 0; i < 12; i++) begin
            send(3'($urandom_range(7)), 16'($urandom), 16'($urandom)); wait_out(lat); e = q.pop_front();
            n++; if (obs() !== e) begin fails++; $display("FAIL rand_%0d: got %h required %h", i, obs(), e); end
            release_out();
            n++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rand_ready_%0d: ir=%b required 1", i, in_ready); end
        end
    endtask
    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_slt_shift();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end
endmodule
